// File: rtl/reader_pie_tx.sv
// rtl/reader_pie_tx.sv - Reader-side PIE forward-link transmitter for EPC Gen2.
// Serialises delimiter, data-0, RTcal, optional TRcal and MSB-first data symbols.
module reader_pie_tx #(
  parameter int DELIM_CLKS = 8,
  parameter int TARI_CLKS  = 16,
  parameter int PW_CLKS    = 8,
  parameter int RTCAL_CLKS = 48,
  parameter int TRCAL_CLKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        preamble_sel,
  input  logic [6:0]  cmd_len,
  input  logic [63:0] cmd_bits,
  output logic        pie_out,
  output logic        busy,
  output logic        done,
  output logic [6:0]  bits_sent
);

  typedef enum logic [3:0] {
    IDLE, DELIM, D0_HI, D0_LO, RT_HI, RT_LO, TR_HI, TR_LO, DAT_HI, DAT_LO, FIN
  } state_t;

  // Counter reload values are duration-1: a state lasts until the counter reaches zero.
  localparam logic [9:0] DELIM_N = 10'(DELIM_CLKS - 1);
  localparam logic [9:0] D0H_N   = 10'(TARI_CLKS - PW_CLKS - 1);
  localparam logic [9:0] D1H_N   = 10'(2 * TARI_CLKS - PW_CLKS - 1);
  localparam logic [9:0] PW_N    = 10'(PW_CLKS - 1);
  localparam logic [9:0] RTH_N   = 10'(RTCAL_CLKS - PW_CLKS - 1);
  localparam logic [9:0] TRH_N   = 10'(TRCAL_CLKS - PW_CLKS - 1);

  state_t      state, state_n;
  logic [9:0]  cnt, cnt_n;
  logic [63:0] shreg, shreg_n;
  logic [6:0]  len_q, len_n;
  logic        psel_q, psel_n;
  logic        pie_n, busy_n, done_n;
  logic [6:0]  bits_n;
  logic [6:0]  bits_inc;
  logic        last;

  assign last     = (cnt == 10'd0);
  assign bits_inc = bits_sent + 7'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      len_q     <= '0;
      psel_q    <= 1'b0;
      pie_out   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bits_sent <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      len_q     <= len_n;
      psel_q    <= psel_n;
      pie_out   <= pie_n;
      busy      <= busy_n;
      done      <= done_n;
      bits_sent <= bits_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt - 10'd1;
    shreg_n = shreg;
    len_n   = len_q;
    psel_n  = psel_q;
    pie_n   = pie_out;
    busy_n  = busy;
    done_n  = 1'b0;
    bits_n  = bits_sent;

    case (state)
      IDLE: begin
        cnt_n  = '0;
        pie_n  = 1'b1;
        busy_n = 1'b0;
        if (start) begin
          psel_n  = preamble_sel;
          len_n   = (cmd_len > 7'd64) ? 7'd64 : cmd_len;
          shreg_n = cmd_bits;
          bits_n  = '0;
          busy_n  = 1'b1;
          pie_n   = 1'b0;
          cnt_n   = DELIM_N;
          state_n = DELIM;
        end
      end
      DELIM: if (last) begin
        state_n = D0_HI; pie_n = 1'b1; cnt_n = D0H_N;
      end
      D0_HI: if (last) begin
        state_n = D0_LO; pie_n = 1'b0; cnt_n = PW_N;
      end
      D0_LO: if (last) begin
        state_n = RT_HI; pie_n = 1'b1; cnt_n = RTH_N;
      end
      RT_HI: if (last) begin
        state_n = RT_LO; pie_n = 1'b0; cnt_n = PW_N;
      end
      RT_LO: if (last) begin
        pie_n = 1'b1;
        if (psel_q) begin
          state_n = TR_HI; cnt_n = TRH_N;
        end else if (len_q != 7'd0) begin
          state_n = DAT_HI; cnt_n = shreg[63] ? D1H_N : D0H_N;
        end else begin
          state_n = FIN; cnt_n = '0; done_n = 1'b1; busy_n = 1'b0;
        end
      end
      TR_HI: if (last) begin
        state_n = TR_LO; pie_n = 1'b0; cnt_n = PW_N;
      end
      TR_LO: if (last) begin
        pie_n = 1'b1;
        if (len_q != 7'd0) begin
          state_n = DAT_HI; cnt_n = shreg[63] ? D1H_N : D0H_N;
        end else begin
          state_n = FIN; cnt_n = '0; done_n = 1'b1; busy_n = 1'b0;
        end
      end
      DAT_HI: if (last) begin
        state_n = DAT_LO; pie_n = 1'b0; cnt_n = PW_N;
      end
      DAT_LO: if (last) begin
        // The next symbol's width comes from the bit that is about to become MSB.
        shreg_n = {shreg[62:0], 1'b0};
        bits_n  = bits_inc;
        pie_n   = 1'b1;
        if (bits_inc == len_q) begin
          state_n = FIN; cnt_n = '0; done_n = 1'b1; busy_n = 1'b0;
        end else begin
          state_n = DAT_HI; cnt_n = shreg[62] ? D1H_N : D0H_N;
        end
      end
      FIN: begin
        cnt_n   = '0;
        pie_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pie_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reader_pie_tx.sv
// tb/tb_reader_pie_tx.sv - Directed self-checking bench for reader_pie_tx.
module tb_reader_pie_tx;
  localparam int T = 16, P = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        preamble_sel = 1'b0;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_bits = '0;
  logic        pie_out, busy, done;
  logic [6:0]  bits_sent;

  int checks = 0;
  int errors = 0;
  int runs[$];
  int exp_runs[$];
  int nfall, done_cyc, busy_cyc;

  reader_pie_tx dut (
    .clk(clk), .reset(reset), .start(start), .preamble_sel(preamble_sel),
    .cmd_len(cmd_len), .cmd_bits(cmd_bits), .pie_out(pie_out), .busy(busy),
    .done(done), .bits_sent(bits_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs are encoded as level*10000 + length in cycles.
  task automatic build_exp(input logic ps, input int len, input logic [63:0] bits);
    int n;
    n = (len > 64) ? 64 : len;
    exp_runs.delete();
    exp_runs.push_back(8);
    exp_runs.push_back(10000 + T - P);
    exp_runs.push_back(P);
    exp_runs.push_back(10000 + 48 - P);
    exp_runs.push_back(P);
    if (ps) begin
      exp_runs.push_back(10000 + 64 - P);
      exp_runs.push_back(P);
    end
    for (int i = 0; i < n; i++) begin
      exp_runs.push_back(10000 + (bits[63-i] ? 2*T - P : T - P));
      exp_runs.push_back(P);
    end
  endtask

  task automatic run_frame();
    int cur, len;
    logic prev;
    runs.delete();
    nfall = 0; busy_cyc = 0; done_cyc = -1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    prev = 1'b1; cur = -1; len = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (cur < 0) begin
        cur = int'(pie_out); len = 1;
      end else if (int'(pie_out) == cur) begin
        len++;
      end else begin
        runs.push_back(cur * 10000 + len);
        cur = int'(pie_out); len = 1;
      end
      if (prev && !pie_out) nfall++;
      prev = pie_out;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) chk("timeout", 0, 1);
  endtask

  task automatic do_frame(input string tag, input logic ps, input int len, input logic [63:0] bits);
    int n, tot, m;
    n = (len > 64) ? 64 : len;
    tot = 0;
    preamble_sel = ps; cmd_len = 7'(len); cmd_bits = bits;
    build_exp(ps, len, bits);
    foreach (exp_runs[i]) tot += exp_runs[i] % 10000;
    run_frame();
    chk($sformatf("%s_nruns", tag), runs.size(), exp_runs.size());
    m = (runs.size() < exp_runs.size()) ? runs.size() : exp_runs.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_run%0d", tag, i), runs[i], exp_runs[i]);
    chk($sformatf("%s_falls", tag), nfall, 3 + int'(ps) + n);
    chk($sformatf("%s_done_cyc", tag), done_cyc, tot);
    chk($sformatf("%s_busy_cyc", tag), busy_cyc, tot);
    chk($sformatf("%s_bits", tag), int'(bits_sent), n);
    chk($sformatf("%s_pie_at_done", tag), int'(pie_out), 1);
    chk($sformatf("%s_busy_at_done", tag), int'(busy), 0);
    @(negedge clk);
    chk($sformatf("%s_done_once", tag), int'(done), 0);
    chk($sformatf("%s_bits_hold", tag), int'(bits_sent), n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pie", int'(pie_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bits", int'(bits_sent), 0);
    reset = 1'b1;
    @(negedge clk);

    do_frame("fsync", 1'b0, 0, 64'h0);
    do_frame("query", 1'b1, 4, {4'b1000, 60'h0});
    do_frame("b2b", 1'b1, 3, {3'b101, 61'h0});
    do_frame("alt64", 1'b0, 64, 64'hAAAA_AAAA_AAAA_AAAA);
    do_frame("clamp", 1'b0, 100, 64'hAAAA_AAAA_AAAA_AAAA);

    fork
      do_frame("ignbusy", 1'b0, 8, {8'hC5, 56'h0});
      begin
        repeat (40) @(negedge clk);
        start = 1'b1; preamble_sel = 1'b1; cmd_len = 7'd2; cmd_bits = '1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    preamble_sel = 1'b0; cmd_len = 7'd4; cmd_bits = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (83) @(negedge clk);
    chk("mid_pie_low", int'(pie_out), 0);
    reset = 1'b0;
    #1;
    chk("arst_pie", int'(pie_out), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_bits", int'(bits_sent), 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wins_busy", int'(busy), 0);
    chk("rst_wins_done", int'(done), 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    do_frame("after_rst", 1'b1, 5, {5'b01101, 59'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
